// File: rtl/hs_ram_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hs_arb_pkg : shared state encoding and counter sizing for the     |
// | hiscore RAM arbiter.                          Rev 1.0             |
// +--------------------------------------------------------------------+
package hs_arb_pkg;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_PAUSE_WAIT = 3'd1,
      S_SETTLE     = 3'd2,
      S_GRANTED    = 3'd3,
      S_RELEASE    = 3'd4
   } state_t;

   // One counter serves all three phases, so it must hold the largest load.
   function automatic int cnt_width(input int timeout, input int settle, input int guard);
      int m;
      m = timeout;
      if (settle > m) m = settle;
      if (guard > m) m = guard;
      return $clog2(m + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/hs_ram_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hs_ram_arbiter_if : hiscore, pause, CPU and RAM signals around    |
// | the arbiter.                                  Rev 1.0             |
// +--------------------------------------------------------------------+
interface hs_ram_arbiter_if #(
   parameter int AW = 11,
   parameter int DW = 8
);
   logic          hs_req;
   logic          hs_ce;
   logic          hs_we;
   logic [AW-1:0] hs_addr;
   logic [DW-1:0] hs_wdata;
   logic          hs_grant;
   logic [DW-1:0] hs_rdata;
   logic          hs_rvalid;
   logic          hs_abort;
   logic          pause_req;
   logic          paused;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_we;
   logic [DW-1:0] cpu_rdata;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic          ram_we;
   logic [DW-1:0] ram_rdata;

   modport slave (
      input  hs_req, hs_ce, hs_we, hs_addr, hs_wdata, paused,
             cpu_addr, cpu_wdata, cpu_we, ram_rdata,
      output hs_grant, hs_rdata, hs_rvalid, hs_abort, pause_req,
             cpu_rdata, ram_addr, ram_wdata, ram_we
   );

   modport master (
      output hs_req, hs_ce, hs_we, hs_addr, hs_wdata, paused,
             cpu_addr, cpu_wdata, cpu_we, ram_rdata,
      input  hs_grant, hs_rdata, hs_rvalid, hs_abort, pause_req,
             cpu_rdata, ram_addr, ram_wdata, ram_we
   );
endinterface
`default_nettype wire

// File: rtl/hs_ram_arbiter_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hs_arb_timer : loadable saturating down-counter with zero flag.   |
// |                                               Rev 1.0             |
// +--------------------------------------------------------------------+
module hs_arb_timer #(
   parameter int W = 4
) (
   input  wire logic         clk,
   input  wire logic         rst,
   input  wire logic         load,
   input  wire logic [W-1:0] load_val,
   input  wire logic         dec,
   output logic              zero
);
   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_cnt <= '0;
      else if (load)
         r_cnt <= load_val;
      else if (dec && (r_cnt != '0))
         r_cnt <= r_cnt - 1'b1;
   end

   assign zero = (r_cnt == '0);
endmodule
`default_nettype wire

// File: rtl/hs_ram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hs_ram_arbiter : hands the work-RAM port to the hiscore engine    |
// | while the CPU is paused.                      Rev 1.0             |
// +--------------------------------------------------------------------+
module hs_ram_arbiter
   import hs_arb_pkg::*;
#(
   parameter int AW      = 11,
   parameter int DW      = 8,
   parameter int SETTLE  = 4,
   parameter int GUARD   = 2,
   parameter int TIMEOUT = 1024
) (
   input  wire logic       clk_sys,
   input  wire logic       reset,
   hs_ram_arbiter_if.slave bus
);
   localparam int                  c_CNT_W      = cnt_width(TIMEOUT, SETTLE, GUARD);
   localparam logic [c_CNT_W-1:0] c_TIMEOUT_LD = c_CNT_W'(TIMEOUT - 1);
   localparam logic [c_CNT_W-1:0] c_SETTLE_LD  = c_CNT_W'(SETTLE - 1);
   localparam logic [c_CNT_W-1:0] c_GUARD_LD   = c_CNT_W'(GUARD - 1);

   state_t               r_state, w_state_nx;
   logic                 r_pause_req, w_pause_nx;
   logic                 r_grant, w_grant_nx;
   logic                 r_abort, w_abort_nx;
   logic                 r_armed, w_armed_nx;
   logic                 w_ld, w_dec, w_zero;
   logic [c_CNT_W-1:0]   w_ld_val;
   logic                 r_rd_p1, r_rvalid;
   logic [DW-1:0]        r_rdata;
   logic                 w_hs_rd;
   logic [AW-1:0]        w_ram_addr;
   logic [DW-1:0]        w_ram_wdata;

   hs_arb_timer #(.W(c_CNT_W)) u_timer (
      .clk      (clk_sys),
      .rst      (reset),
      .load     (w_ld),
      .load_val (w_ld_val),
      .dec      (w_dec),
      .zero     (w_zero)
   );

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_pause_req <= 1'b0;
         r_grant     <= 1'b0;
         r_abort     <= 1'b0;
         r_armed     <= 1'b1;
      end else begin
         r_state     <= w_state_nx;
         r_pause_req <= w_pause_nx;
         r_grant     <= w_grant_nx;
         r_abort     <= w_abort_nx;
         r_armed     <= w_armed_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_pause_nx = r_pause_req;
      w_grant_nx = r_grant;
      w_abort_nx = 1'b0;
      w_armed_nx = r_armed;
      w_ld       = 1'b0;
      w_ld_val   = '0;
      w_dec      = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_pause_nx = 1'b0;
            w_grant_nx = 1'b0;
            if (!bus.hs_req) begin
               w_armed_nx = 1'b1;
            end else if (r_armed) begin
               w_state_nx = S_PAUSE_WAIT;
               w_pause_nx = 1'b1;
               w_ld       = 1'b1;
               w_ld_val   = c_TIMEOUT_LD;
            end
         end
         S_PAUSE_WAIT: begin
            if (!bus.hs_req) begin
               w_state_nx = S_RELEASE;
               w_ld       = 1'b1;
               w_ld_val   = c_GUARD_LD;
            end else if (bus.paused) begin
               w_state_nx = S_SETTLE;
               w_ld       = 1'b1;
               w_ld_val   = c_SETTLE_LD;
            end else if (w_zero) begin
               // Engine must drop hs_req before it is served again.
               w_state_nx = S_IDLE;
               w_abort_nx = 1'b1;
               w_pause_nx = 1'b0;
               w_armed_nx = 1'b0;
            end else begin
               w_dec = 1'b1;
            end
         end
         S_SETTLE: begin
            if (!bus.hs_req) begin
               w_state_nx = S_RELEASE;
               w_ld       = 1'b1;
               w_ld_val   = c_GUARD_LD;
            end else if (!bus.paused) begin
               w_state_nx = S_PAUSE_WAIT;
               w_ld       = 1'b1;
               w_ld_val   = c_TIMEOUT_LD;
            end else if (w_zero) begin
               w_state_nx = S_GRANTED;
               w_grant_nx = 1'b1;
            end else begin
               w_dec = 1'b1;
            end
         end
         S_GRANTED: begin
            // A request drop wins over a simultaneous pause loss: clean release.
            if (!bus.hs_req || !bus.paused) begin
               w_state_nx = S_RELEASE;
               w_grant_nx = 1'b0;
               w_abort_nx = bus.hs_req;
               w_ld       = 1'b1;
               w_ld_val   = c_GUARD_LD;
            end
         end
         S_RELEASE: begin
            if (w_zero) begin
               w_state_nx = S_IDLE;
               w_pause_nx = 1'b0;
            end else begin
               w_dec = 1'b1;
            end
         end
         default: begin
            w_state_nx = S_IDLE;
            w_pause_nx = 1'b0;
            w_grant_nx = 1'b0;
         end
      endcase
   end

   // Two-stage read pipe: RAM latency plus the hs_rdata register.
   assign w_hs_rd = r_grant & bus.hs_ce & ~bus.hs_we;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         r_rd_p1  <= 1'b0;
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
      end else begin
         r_rd_p1  <= w_hs_rd;
         r_rvalid <= r_rd_p1;
         if (r_rd_p1)
            r_rdata <= bus.ram_rdata;
      end
   end

   assign w_ram_addr  = r_grant ? bus.hs_addr  : bus.cpu_addr;
   assign w_ram_wdata = r_grant ? bus.hs_wdata : bus.cpu_wdata;

   assign bus.ram_addr  = w_ram_addr;
   assign bus.ram_wdata = w_ram_wdata;
   assign bus.ram_we    = ~reset & (r_grant ? (bus.hs_ce & bus.hs_we) : bus.cpu_we);
   assign bus.cpu_rdata = bus.ram_rdata;
   assign bus.hs_grant  = r_grant;
   assign bus.hs_rdata  = r_rdata;
   assign bus.hs_rvalid = r_rvalid;
   assign bus.hs_abort  = r_abort;
   assign bus.pause_req = r_pause_req;
endmodule
`default_nettype wire

// File: tb/tb_hs_ram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_hs_ram_arbiter : randomized scoreboard bench for hs_ram_arbiter|
// |                                               Rev 1.0             |
// +--------------------------------------------------------------------+
module tb_hs_ram_arbiter;
   localparam int AW = 11, DW = 8, SETTLE = 4, GUARD = 2, TIMEOUT = 1024;

   logic clk_sys = 1'b0;
   logic reset;
   always #5 clk_sys = ~clk_sys;

   hs_ram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   hs_ram_arbiter #(.AW(AW), .DW(DW), .SETTLE(SETTLE), .GUARD(GUARD), .TIMEOUT(TIMEOUT)) dut (
      .clk_sys (clk_sys),
      .reset   (reset),
      .bus     (bus)
   );

   logic [DW-1:0] mem     [0:(1<<AW)-1];
   logic [DW-1:0] ref_mem [0:(1<<AW)-1];

   always @(posedge clk_sys) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      bus.ram_rdata <= mem[bus.ram_addr];
   end

   int cyc = 0;
   always @(posedge clk_sys) cyc <= cyc + 1;

   typedef struct { logic [DW-1:0] data; int due; } exp_t;
   exp_t sb[$];
   exp_t mon_e;
   int n_checks = 0, n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   always @(negedge clk_sys) begin
      if (!reset) begin
         if (bus.hs_rvalid) begin
            if (sb.size() == 0) begin
               check("rvalid_unexpected", 1, 0);
            end else begin
               mon_e = sb.pop_front();
               check("rdata", bus.hs_rdata, mon_e.data);
               check("rvalid_cycle", cyc, mon_e.due);
            end
         end else if (sb.size() != 0 && cyc >= sb[0].due) begin
            check("rvalid_missing", 0, 1);
            void'(sb.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clk_sys);
      #1;
   endtask

   // One access cycle; the expected RAM-side view follows from who owns the port.
   task automatic do_op(input bit ce, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit granted);
      bit            cwe;
      logic [AW-1:0] ca;
      logic [DW-1:0] cd;
      cwe = 1'($urandom_range(0, 1));
      ca  = AW'($urandom);
      cd  = DW'($urandom);
      bus.hs_ce = ce; bus.hs_we = we; bus.hs_addr = a; bus.hs_wdata = d;
      bus.cpu_we = cwe; bus.cpu_addr = ca; bus.cpu_wdata = cd;
      #2;
      check("ram_we", bus.ram_we, granted ? (ce & we) : cwe);
      check("ram_addr", bus.ram_addr, granted ? a : ca);
      if (granted) begin
         if (ce && we) ref_mem[a] = d;
         if (ce && !we) sb.push_back('{ref_mem[a], cyc + 2});
      end else if (cwe) begin
         ref_mem[ca] = cd;
      end
      step();
      bus.hs_ce = 1'b0;
      bus.cpu_we = 1'b0;
   endtask

   task automatic req_pause();
      int k;
      k = 0;
      bus.hs_req = 1'b1;
      do begin step(); k++; end while (!bus.pause_req && k < 8);
      check("pause_req_latency", k, 1);
   endtask

   task automatic acquire(input int delay);
      req_pause();
      repeat (delay) step();
      check("grant_before_paused", bus.hs_grant, 0);
      bus.paused = 1'b1;
      step();
      for (int k = 0; k <= SETTLE; k++) begin
         check("grant_settle", bus.hs_grant, (k == SETTLE) ? 1 : 0);
         if (k < SETTLE) step();
      end
   endtask

   task automatic random_ops(input int n);
      for (int i = 0; i < n; i++)
         do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      for (int i = 0; i < (1 << AW); i++) begin
         mem[i] = DW'($urandom);
         ref_mem[i] = mem[i];
      end
      reset = 1'b1;
      bus.hs_req = 0; bus.hs_ce = 0; bus.hs_we = 0; bus.hs_addr = '0; bus.hs_wdata = '0;
      bus.paused = 0; bus.cpu_addr = 11'h155; bus.cpu_wdata = 8'h33; bus.cpu_we = 1'b1;
      repeat (3) step();
      check("rst_grant", bus.hs_grant, 0);
      check("rst_pause_req", bus.pause_req, 0);
      check("rst_rvalid", bus.hs_rvalid, 0);
      check("rst_abort", bus.hs_abort, 0);
      check("rst_rdata", bus.hs_rdata, 0);
      check("rst_ram_we", bus.ram_we, 0);
      check("rst_ram_addr", bus.ram_addr, 11'h155);
      bus.cpu_we = 1'b0;
      reset = 1'b0;
      step();

      // Normal grant, directed accesses, then random traffic
      acquire(10);
      bus.hs_addr = 11'h123; bus.cpu_addr = 11'h456;
      #1 check("mux_hs_addr", bus.ram_addr, 11'h123);
      do_op(1, 1, 11'h0A0, 8'h5C, 1);
      do_op(1, 0, 11'h0A0, 8'h00, 1);
      do_op(1, 0, 11'h0A1, 8'h00, 1);
      do_op(1, 1, 11'h3FF, 8'hA5, 1);
      do_op(1, 0, 11'h3FF, 8'h00, 1);
      random_ops(40);

      // Release with a read on the last granted cycle
      bus.hs_req = 1'b0;
      do_op(1, 0, AW'($urandom), 8'h00, 1);
      check("rel_grant", bus.hs_grant, 0);
      check("rel_pause_1", bus.pause_req, 1);
      check("rel_abort", bus.hs_abort, 0);
      do_op(1, 1, AW'($urandom), DW'($urandom), 0);
      check("rel_pause_2", bus.pause_req, 1);
      do_op(1, 0, AW'($urandom), 8'h00, 0);
      check("rel_pause_end", bus.pause_req, 0);
      bus.paused = 1'b0;
      repeat (3) step();

      // Pause lost while granted
      acquire($urandom_range(0, 5));
      random_ops(10);
      bus.paused = 1'b0;
      step();
      check("plost_abort", bus.hs_abort, 1);
      check("plost_grant", bus.hs_grant, 0);
      check("plost_pause", bus.pause_req, 1);
      step();
      check("plost_abort_pulse", bus.hs_abort, 0);
      bus.hs_req = 1'b0;
      repeat (4) step();
      check("plost_pause_end", bus.pause_req, 0);

      // Request and pause drop together: clean release
      acquire($urandom_range(0, 5));
      random_ops(5);
      bus.hs_req = 1'b0; bus.paused = 1'b0;
      step();
      check("simul_abort", bus.hs_abort, 0);
      check("simul_grant", bus.hs_grant, 0);
      check("simul_pause", bus.pause_req, 1);
      repeat (3) step();
      check("simul_pause_end", bus.pause_req, 0);

      // Timeout while paused never arrives
      req_pause();
      bad = 0;
      for (int k = 1; k < TIMEOUT; k++) begin
         step();
         if (bus.hs_abort || bus.hs_grant || !bus.pause_req) bad++;
      end
      check("timeout_early", bad, 0);
      step();
      check("timeout_abort", bus.hs_abort, 1);
      check("timeout_pause", bus.pause_req, 0);
      check("timeout_grant", bus.hs_grant, 0);
      step();
      check("timeout_abort_pulse", bus.hs_abort, 0);
      bad = 0;
      repeat (4) begin step(); if (bus.pause_req) bad++; end
      check("timeout_no_rearm", bad, 0);
      bus.hs_req = 1'b0;
      step();
      bus.hs_req = 1'b1;
      step();
      check("timeout_rearm", bus.pause_req, 1);
      bus.hs_req = 1'b0;
      repeat (4) step();

      // Asynchronous reset in the middle of a grant
      acquire(3);
      random_ops(8);
      repeat (3) step();
      bus.hs_ce = 1'b1; bus.hs_we = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 11'h2AA;
      #1 reset = 1'b1;
      #1;
      check("arst_pause", bus.pause_req, 0);
      check("arst_grant", bus.hs_grant, 0);
      check("arst_ram_we", bus.ram_we, 0);
      check("arst_ram_addr", bus.ram_addr, 11'h2AA);
      bus.hs_ce = 1'b0; bus.cpu_we = 1'b0; bus.hs_req = 1'b0; bus.paused = 1'b0;
      step();
      reset = 1'b0;
      repeat (2) step();
      check("arst_idle", bus.pause_req, 0);
      bus.hs_req = 1'b1;
      step();
      check("arst_serve", bus.pause_req, 1);
      bus.hs_req = 1'b0;
      repeat (5) step();

      check("scoreboard_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/hs_ram_arbiter.md
Name: hs_ram_arbiter

Overview:
- Shares the core's work-RAM port between the running CPU and the hiscore save/restore engine.
- On a hiscore request it asks the pause system to halt the CPU, waits for pause acknowledge plus a settle interval, then grants the RAM port to the hiscore engine.
- On release it holds the pause for a guard interval so in-flight reads drain.
- Sits between hiscore, pause and the game core's RAM port in the top level.

Parameters:
- AW, 11, RAM address width
- DW, 8, RAM data width
- SETTLE, 4, cycles from paused=1 to grant (1..15)
- GUARD, 2, cycles pause_req is held after hs_req drops (>=2 to cover read latency)
- TIMEOUT, 1024, max cycles waiting for paused before abort

Ports:
- clk_sys  in  1  system clock (12 MHz)
- reset  in  1  asynchronous, active-high reset
- hs_req  in  1  hiscore engine requests the RAM port (level)
- hs_ce  in  1  hiscore access strobe, valid only while hs_grant=1
- hs_we  in  1  write qualifier for hs_ce
- hs_addr  in  AW  hiscore address
- hs_wdata  in  DW  hiscore write data
- hs_grant  out  1  port owned by hiscore engine
- hs_rdata  out  DW  registered read data
- hs_rvalid  out  1  one-cycle pulse, hs_rdata valid
- hs_abort  out  1  one-cycle pulse: pause timeout or pause lost while granted
- pause_req  out  1  request to pause system
- paused  in  1  CPU halted acknowledge
- cpu_addr  in  AW  core address
- cpu_wdata  in  DW  core write data
- cpu_we  in  1  core write enable
- cpu_rdata  out  DW  read data to core
- ram_addr  out  AW  shared RAM address
- ram_wdata  out  DW  shared RAM write data
- ram_we  out  1  shared RAM write enable
- ram_rdata  in  DW  shared RAM read data (synchronous, 1-cycle latency)

Behaviour:
- Reset (async, any state): state=IDLE. All outputs are 0 (hs_grant, hs_rvalid, hs_abort, pause_req, hs_rdata, ram_we), counters are 0, and the RAM mux selects the CPU.
- RAM mux (combinational on the registered select):
  - CPU selected: ram_* = cpu_*.
  - hiscore selected: ram_addr=hs_addr, ram_wdata=hs_wdata, ram_we=hs_ce&hs_we.
  - cpu_we is ignored while hiscore is selected.
  - cpu_rdata = ram_rdata at all times.
- State machine:
  - IDLE: pause_req=0. On hs_req=1, go to PAUSE_WAIT, set pause_req=1 and load the timeout counter with TIMEOUT-1.
  - PAUSE_WAIT:
    - hs_req=0: go to RELEASE.
    - Else paused=1: go to SETTLE and load SETTLE-1.
    - Else counter=0: pulse hs_abort, drop pause_req, go to IDLE. The engine must drop hs_req before it is re-served. IDLE re-arms only after it has seen hs_req=0 for at least 1 cycle.
    - Otherwise decrement the counter.
  - SETTLE:
    - hs_req=0: go to RELEASE.
    - paused=0: return to PAUSE_WAIT with the timeout counter reloaded.
    - counter=0: go to GRANTED, registering hs_grant=1 and select=hiscore.
    - Otherwise decrement.
  - GRANTED:
    - Every hs_ce cycle is an access.
    - Read latency: hs_ce&!hs_we at cycle N gives hs_rdata and hs_rvalid=1 at cycle N+2.
    - Writes are committed at N, with no response.
    - hs_req=0: go to RELEASE, hs_grant=0, select returns to CPU the next cycle. Reads issued earlier still complete.
    - paused=0 while granted: pulse hs_abort, hs_grant=0, go to RELEASE.
  - RELEASE: pause_req held at 1 for GUARD cycles, then IDLE with pause_req=0.
- Simultaneous events:
  - hs_req drop together with paused drop in GRANTED: treated as a normal release, no abort.
  - hs_ce with hs_grant=0: ignored, ram_we stays 0.
- Read pipeline is 2 registers. hs_rvalid never asserts for accesses made without a grant.
- Counters are saturating down-counters sized $clog2(max(TIMEOUT,SETTLE,GUARD)+1).

Decomposition:
- Shared package hs_arb_pkg contains:
  - state enum {IDLE, PAUSE_WAIT, SETTLE, GRANTED, RELEASE}
  - localparam function for counter width
- One sub-module, hs_arb_timer: a loadable down-counter with a zero flag, shared by the TIMEOUT, SETTLE and GUARD phases.

Test Plan:
- Normal grant: hs_req=1, paused rises 10 cycles after pause_req. Expect hs_grant=1 exactly SETTLE=4 cycles after paused is sampled high, ram_addr switches to hs_addr.
- Read latency: in GRANTED, hs_ce=1, hs_we=0, addr 0x0A0, RAM holds 0x5C. Expect hs_rvalid=1 and hs_rdata=0x5C at N+2. Back-to-back reads of 0x0A0 and 0x0A1 give two consecutive rvalid pulses.
- Write path: hs_ce=1, hs_we=1, addr 0x3FF, data 0xA5 → ram_we=1 for that cycle. cpu_we=1 during grant never reaches ram_we.
- Timeout: hs_req=1, paused held 0 → hs_abort pulses at cycle TIMEOUT, pause_req=0, hs_grant never asserted. No re-arm until hs_req has been low.
- Release/guard: drop hs_req in GRANTED → hs_grant=0 next cycle, pause_req stays 1 for GUARD=2 cycles then 0. A read issued on the last granted cycle still returns rvalid.
- Reset mid-grant: assert reset during GRANTED → pause_req, hs_grant and ram_we are 0 immediately (async). ram_addr follows cpu_addr. After deassert the block is in IDLE.
